// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
// Pure declarations, no timing.
// No flow control of its own.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    // Wide enough for lock bursts of up to 15 grants.
    localparam int LOCK_CNT_W = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Position offs steps after base on a ring of n requesters.
    function automatic int rr_idx(input int base, input int offs, input int n);
        return (base + offs) % n;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr_i wins.
// Purely combinational, zero latency.
// No backpressure; losers simply see no grant this cycle.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic             found;
    logic [IDX_W-1:0] k;

    // Walk the ring starting at ptr_i and latch onto the first active request.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDX_W'(rr_idx(int'(ptr_i), i, NREQ));
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM among NREQ requesters, round-robin with a bounded lock.
// Grant is combinational (0 cycles); read data returns registered 1 cycle after grant.
// Losing requesters hold req_i until granted; at most one access per cycle overall.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ-1:0]          lock_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*DATA_W-1:0]   wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     ram_load_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic [DATA_W-1:0]        ram_data_o,
    input  logic [DATA_W-1:0]        ram_data_i
);

    localparam int IDX_W = $clog2(NREQ);

    // Lock FSM and round-robin pointer state
    lock_state_e            lock_q, lock_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [LOCK_CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    // Per-requester views of the packed buses
    logic [ADDR_W-1:0]      addr_arr  [NREQ];
    logic [DATA_W-1:0]      wdata_arr [NREQ];

    // Picker results and final winner
    logic [NREQ-1:0]        pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   owner_hit;
    logic [NREQ-1:0]        win_vec;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   grant;

    // Registered outputs
    logic [ADDR_W-1:0]      addr_q;
    logic [NREQ-1:0]        rvalid_q;
    logic [DATA_W-1:0]      rdata_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = wdata_i[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A live lock owner that still requests beats the round-robin choice.
    always_comb begin
        owner_hit = (lock_q == LOCKED) && req_i[owner_q];
        win_vec   = pick_gnt;
        win_idx   = pick_idx;
        win_any   = pick_any;
        if (owner_hit) begin
            win_vec          = '0;
            win_vec[owner_q] = 1'b1;
            win_idx          = owner_q;
            win_any          = 1'b1;
        end
    end

    // Nothing is granted while reset is held, even if requests are present.
    assign grant = win_any & rst_ni;

    // State register: pointer, lock owner and burst count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q  <= UNLOCKED;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: pointer always moves past the winner; while locked the owner
    // overrides it anyway, and a lock ending on the count bound hands off naturally.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (grant) begin
            ptr_d = IDX_W'(rr_idx(int'(win_idx), 1, NREQ));
        end
        case (lock_q)
            UNLOCKED: begin
                if (grant && lock_i[win_idx] && (LOCK_MAX > 1)) begin
                    lock_d  = LOCKED;
                    owner_d = win_idx;
                    cnt_d   = LOCK_CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!owner_hit) begin
                    lock_d = UNLOCKED;
                end else if (lock_i[owner_q] && (int'(cnt_q) + 1 < LOCK_MAX)) begin
                    cnt_d = cnt_q + LOCK_CNT_W'(1);
                end else begin
                    lock_d = UNLOCKED;
                end
            end
            default: lock_d = UNLOCKED;
        endcase
    end

    // Outputs: grant vector and RAM port mux; address parks on its last value when idle.
    always_comb begin
        gnt_o      = grant ? win_vec : '0;
        ram_load_o = grant & we_i[win_idx];
        ram_addr_o = grant ? addr_arr[win_idx] : addr_q;
        ram_data_o = wdata_arr[win_idx];
    end

    // Remember the last granted address for idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
        end else if (grant) begin
            addr_q <= addr_arr[win_idx];
        end
    end

    // Capture RAM data at the end of every grant (pre-write content on writes).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else if (grant) begin
            rvalid_q <= win_vec;
            rdata_q  <= ram_data_i;
        end else begin
            rvalid_q <= '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a queue-free behavioural model.
// Compares every cycle at the falling edge; inputs change 1 time unit after the rising edge.
// Requesters hold their request until the model says it was granted.
module tb_ram_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 15;
    localparam int DW   = 16;
    localparam int LMAX = 4;
    localparam int IW   = $clog2(NREQ);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req, we, lock;
    logic [AW-1:0]       a_addr [NREQ];
    logic [DW-1:0]       a_wd   [NREQ];
    logic [NREQ*AW-1:0]  addr_v;
    logic [NREQ*DW-1:0]  wd_v;

    logic [NREQ-1:0]     gnt, rvalid;
    logic [DW-1:0]       rdata, ram_wd, ram_rd;
    logic                ram_load;
    logic [AW-1:0]       ram_addr;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign addr_v[g*AW +: AW] = a_addr[g];
        assign wd_v[g*DW +: DW]   = a_wd[g];
    end

    ram_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .we_i       (we),
        .lock_i     (lock),
        .addr_i     (addr_v),
        .wdata_i    (wd_v),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .ram_load_o (ram_load),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_wd),
        .ram_data_i (ram_rd)
    );

    // Physical RAM seen by the DUT, and the model's private copy.
    logic [DW-1:0] ram [0:32767];
    logic [DW-1:0] mdl [0:32767];
    assign ram_rd = ram[ram_addr];
    always @(posedge clk) if (ram_load) ram[ram_addr] <= ram_wd;

    // Model state
    int              m_ptr = 0;
    bit              m_locked = 1'b0;
    logic [IW-1:0]   m_owner = '0;
    int              m_cnt = 0;
    logic [NREQ-1:0] m_rvalid = '0;
    logic [NREQ-1:0] m_gnt = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic [AW-1:0]   m_last = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin : cmp
        int            w;
        logic [IW-1:0] wi, ki;
        logic [AW-1:0] ea;
        logic          el;
        if (!rst_n) begin
            chk("rst_gnt",    32'(gnt),      32'h0);
            chk("rst_load",   32'(ram_load), 32'h0);
            chk("rst_rvalid", 32'(rvalid),   32'h0);
            chk("rst_rdata",  32'(rdata),    32'h0);
            chk("rst_addr",   32'(ram_addr), 32'h0);
            m_ptr = 0; m_locked = 1'b0; m_owner = '0; m_cnt = 0;
            m_rvalid = '0; m_gnt = '0; m_rdata = '0; m_last = '0;
        end else begin
            w  = -1;
            wi = '0;
            if (m_locked && req[m_owner]) begin
                w = int'(m_owner);
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    ki = IW'((m_ptr + i) % NREQ);
                    if (w < 0 && req[ki]) w = int'(ki);
                end
            end
            if (w >= 0) wi = IW'(w);
            m_gnt = (w >= 0) ? (NREQ'(1) << wi) : '0;
            el = (w >= 0) && we[wi];
            ea = (w >= 0) ? a_addr[wi] : m_last;
            chk("gnt",    32'(gnt),      32'(m_gnt));
            chk("load",   32'(ram_load), 32'(el));
            chk("addr",   32'(ram_addr), 32'(ea));
            if (el) chk("wdata", 32'(ram_wd), 32'(a_wd[wi]));
            chk("rvalid", 32'(rvalid),   32'(m_rvalid));
            chk("rdata",  32'(rdata),    32'(m_rdata));
            m_rvalid = m_gnt;
            if (w >= 0) begin
                m_rdata = mdl[ea];
                if (el) mdl[ea] = a_wd[wi];
                m_last = ea;
                m_ptr  = (w + 1) % NREQ;
            end
            if (m_locked) begin
                if (!req[m_owner]) m_locked = 1'b0;
                else if (lock[m_owner] && (m_cnt + 1 < LMAX)) m_cnt = m_cnt + 1;
                else m_locked = 1'b0;
            end else if (w >= 0 && lock[wi] && LMAX > 1) begin
                m_locked = 1'b1;
                m_owner  = wi;
                m_cnt    = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    // Random requester agents
    logic [NREQ-1:0] p_req = '0, p_we = '0, p_lock = '0;
    logic [AW-1:0]   p_addr [NREQ];
    logic [DW-1:0]   p_wd   [NREQ];

    initial begin
        logic [AW-1:0] ai;
        logic [IW-1:0] ki;
        logic [31:0]   rv;
        rst_n = 1'b0;
        req = '1; we = '1; lock = '0;
        for (int k = 0; k < NREQ; k++) begin
            ki = IW'(k);
            a_addr[ki] = '0; a_wd[ki] = '0; p_addr[ki] = '0; p_wd[ki] = '0;
        end
        for (int i = 0; i < 32768; i++) begin
            ai = AW'(i);
            rv = $urandom;
            ram[ai] = rv[DW-1:0];
            mdl[ai] = rv[DW-1:0];
        end
        ram[15'h0010] = 16'hBEEF; mdl[15'h0010] = 16'hBEEF;
        ram[15'h7FFF] = 16'h5555; mdl[15'h7FFF] = 16'h5555;

        // Reset with requests present: nothing may be granted or written.
        step();
        chk("rst_lit_gnt",  32'(gnt),      32'h0);
        chk("rst_lit_load", 32'(ram_load), 32'h0);
        req = '0; we = '0;
        step();
        rst_n = 1'b1;

        // Single read of a preloaded word.
        req = 2'b01; a_addr[0] = 15'h0010;
        look();
        chk("t1_gnt",  32'(gnt),      32'h1);
        chk("t1_addr", 32'(ram_addr), 32'h0010);
        step();
        req = 2'b00;
        look();
        chk("t1_rvalid", 32'(rvalid), 32'h1);
        chk("t1_rdata",  32'(rdata),  32'hBEEF);
        chk("t1_idle",   32'(gnt),    32'h0);

        // Bring the pointer back to 0, then contend.
        step();
        req = 2'b10; a_addr[1] = 15'h0020;
        step();
        req = 2'b11; a_addr[0] = 15'h0100; a_addr[1] = 15'h0200;
        look();
        chk("t2_gnt0",  32'(gnt),      32'h1);
        chk("t2_addr0", 32'(ram_addr), 32'h0100);
        step();
        req = 2'b10;
        look();
        chk("t2_gnt1",  32'(gnt),      32'h2);
        chk("t2_addr1", 32'(ram_addr), 32'h0200);

        // Write then read the top address from requester 1.
        step();
        req = 2'b10; we = 2'b10; a_addr[1] = 15'h7FFF; a_wd[1] = 16'h1234;
        look();
        chk("t3_wgnt",  32'(gnt),      32'h2);
        chk("t3_load",  32'(ram_load), 32'h1);
        chk("t3_wdata", 32'(ram_wd),   32'h1234);
        step();
        we = 2'b00;
        look();
        chk("t3_old_rvalid", 32'(rvalid), 32'h2);
        chk("t3_old_rdata",  32'(rdata),  32'h5555);
        step();
        req = 2'b00;
        look();
        chk("t3_new_rdata", 32'(rdata), 32'h1234);

        // Lock bound: four grants to requester 0, then requester 1.
        step();
        req = 2'b11; lock = 2'b01; a_addr[0] = 15'h0030; a_addr[1] = 15'h0040;
        for (int c = 0; c < 5; c++) begin
            look();
            chk("t4_lock_gnt", 32'(gnt), (c < 4) ? 32'h1 : 32'h2);
            step();
        end

        // Lock release by dropping the request after two grants.
        look();
        chk("t5_gnt_a", 32'(gnt), 32'h1);
        step();
        look();
        chk("t5_gnt_b", 32'(gnt), 32'h1);
        step();
        req = 2'b10; lock = 2'b00;
        look();
        chk("t5_rel_gnt",   32'(gnt),      32'h2);
        chk("t5_mdl_unlck", 32'(m_locked), 32'h0);
        step();
        req = 2'b00;

        // Asynchronous reset in the middle of a locked burst.
        step();
        req = 2'b11; lock = 2'b01;
        look();
        chk("t6_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt",    32'(gnt),      32'h0);
        chk("t6_rst_load",   32'(ram_load), 32'h0);
        chk("t6_rst_rvalid", 32'(rvalid),   32'h0);
        step();
        req = 2'b00; lock = 2'b00; rst_n = 1'b1;
        step();
        req = 2'b11;
        look();
        chk("t6_post_gnt0", 32'(gnt), 32'h1);
        step();
        req = 2'b10;
        look();
        chk("t6_post_gnt1", 32'(gnt), 32'h2);
        step();
        req = 2'b00;
        step();

        // Random traffic over a small address pool so writes and reads collide.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < NREQ; k++) begin
                ki = IW'(k);
                if (p_req[ki] && m_gnt[ki]) p_req[ki] = 1'b0;
                if (!p_req[ki] && $urandom_range(0, 99) < 55) begin
                    p_req[ki]  = 1'b1;
                    p_we[ki]   = ($urandom_range(0, 2) == 0);
                    p_lock[ki] = ($urandom_range(0, 3) == 0);
                    p_wd[ki]   = DW'($urandom);
                    case ($urandom_range(0, 3))
                        0:       p_addr[ki] = 15'h7FFF;
                        1:       p_addr[ki] = 15'h0010;
                        2:       p_addr[ki] = AW'($urandom_range(0, 15));
                        default: p_addr[ki] = AW'($urandom);
                    endcase
                end
                a_addr[ki] = p_addr[ki];
                a_wd[ki]   = p_wd[ki];
            end
            req  = p_req;
            we   = p_we;
            lock = p_lock;
            step();
        end
        req = '0; we = '0; lock = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 32K x 16 data RAM between `NREQ` requesters, such as the CPU data port and a DMA or screen-scan engine. Each cycle it grants at most one request, using a round-robin policy, and drives the RAM's write-enable, address and write-data inputs. Read data is registered and returned one cycle after the grant. A bounded lock lets one requester hold the RAM for back-to-back accesses, for example a read-modify-write.

## Interface
- `NREQ`, default 2: number of requesters, 2..4.
- `ADDR_W`, default 15: RAM address width.
- `DATA_W`, default 16: RAM data width.
- `LOCK_MAX`, default 4: maximum consecutive grants to one locked requester.

- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_i` input NREQ: per-requester access request; held until granted.
- `we_i` input NREQ: per-requester write flag, qualified by `req_i`.
- `lock_i` input NREQ: requester asks to keep ownership after this grant.
- `addr_i` input NREQ*ADDR_W: packed addresses; requester k occupies slice k.
- `wdata_i` input NREQ*DATA_W: packed write data.
- `gnt_o` output NREQ: one-hot grant; access is performed this cycle.
- `rvalid_o` output NREQ: one-hot; `rdata_o` is valid for this requester.
- `rdata_o` output DATA_W: registered read data.
- `ram_load_o` output 1: RAM write enable.
- `ram_addr_o` output ADDR_W: RAM address.
- `ram_data_o` output DATA_W: RAM write data.
- `ram_data_i` input DATA_W: RAM combinational read data.

## Operation
- Winner selection is combinational within the cycle:
  - If a lock is active and its owner has `req_i` high, the owner wins.
  - Otherwise, round-robin starts from pointer `ptr`; the first requester with `req_i` high wins.
- Exactly one `gnt_o` bit is high when any request is eligible; all bits are 0 otherwise.
- Mux: `ram_addr_o` and `ram_data_o` follow the winner's address and data. `ram_load_o` equals `we_i[winner]` AND any-grant.
- With no grant, `ram_addr_o` holds its last granted value (registered copy). `ram_data_o` is a don't-care. `ram_load_o` is 0.
- Pointer update on a granted cycle: `ptr <= winner+1` mod NREQ, unless the lock continues. With no grant, `ptr` is unchanged.
- Lock state machine, states UNLOCKED and LOCKED(owner, count):
  - UNLOCKED -> LOCKED(w, 1) when winner w has `lock_i[w]` high.
  - LOCKED -> LOCKED(count+1) when the owner is granted again with `lock_i` high and count+1 < LOCK_MAX.
  - LOCKED -> UNLOCKED in any of these cases:
    - the owner is granted with `lock_i` low;
    - the owner drops `req_i` (no grant goes to the owner that cycle; normal round-robin applies);
    - count reaches LOCK_MAX. The final grant is issued, then `ptr` = owner+1 forces a hand-off.
- Simultaneous requests with no lock: lowest index at or after `ptr` wins; the others stay pending.
- Write grant: the RAM is written at the clock edge ending the grant cycle. `rvalid_o` still pulses and `rdata_o` returns the pre-write RAM content at that address.

## Timing
- Grant latency is 0 cycles: `gnt_o` is combinational from `req_i` and state in the same cycle.
- Read latency is 1 cycle: data is captured at the edge ending the grant cycle; `rvalid_o[w]`=1 and `rdata_o` are valid for exactly the next cycle.
- `rdata_o` holds its value when no read is returned.
- Throughput is one access per cycle in total. Back-to-back grants to different requesters are allowed.
- Reset (`rst_ni`=0, asynchronous):
  - `ptr`=0 and lock = UNLOCKED.
  - `rvalid_o`=0, `rdata_o`=0, `ram_addr_o`=0.
  - `gnt_o` and `ram_load_o` are forced to 0 while reset is asserted.
- Reset asserted mid-lock or mid-read: the lock is dropped and any pending `rvalid_o` is lost; requesters must re-issue.
- Requesters must not change `addr_i`, `we_i` or `wdata_i` while `req_i` is high and ungranted.

## Structure
- Package `ram_arb_pkg` holds the `ADDR_W`/`DATA_W` defaults, the lock state enum (UNLOCKED, LOCKED) and the `LOCK_CNT_W` constant.
- Sub-module `rr_pick`: purely combinational NREQ-wide round-robin picker.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant and winner index.
- The top level holds `ptr`, the lock FSM, the output mux and the read-data register.

## Test plan
- Single read: preload RAM[0x0010]=0xBEEF; req0 reads 0x0010 -> `gnt_o`=01 in cycle N; `rvalid_o`=01 with `rdata_o`=0xBEEF in N+1.
- Contention: req0 and req1 both high with `ptr`=0 -> grant sequence 01, 10 on consecutive cycles; ram_addr_o follows each requester's address in turn.
- Write then read, same address: req1 writes 0x1234 to 0x7FFF, then reads it -> the read returns 0x1234. The write-cycle `rvalid_o` returns the old content.
- Lock bound (LOCK_MAX=4): req0 holds `lock_i` with req1 pending -> 4 consecutive grants to req0, then req1 is granted on the 5th cycle.
- Lock release: req0 locks, then drops `req_i` after 2 grants -> req1 is granted the next cycle and the lock state returns to UNLOCKED.
- Async reset mid-lock: assert `rst_ni`=0 between edges -> `gnt_o`, `ram_load_o` and `rvalid_o` are 0 immediately. After release, `ptr`=0 and req0 has priority.
